// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, store
// modes and the big-endian lane-mask function used by the store aligner.
package dmem_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  typedef enum logic [1:0] {ST_WORD, ST_LEFT, ST_RIGHT} store_mode_t;

  typedef logic [3:0] lane_mask_t;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  // Mask bit j enables bits [8j+7:8j]; big-endian lane n therefore maps to bit 3-n.
  function automatic lane_mask_t lane_mask(input store_mode_t mode, input logic [1:0] k);
    lane_mask_t m;
    m = '1;
    case (mode)
      ST_LEFT:  m = m >> k;
      ST_RIGHT: m = m << (2'd3 - k);
      default:  m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_store_align.sv
// Store aligner: turns WriteL/WriteR and the byte offset into a lane mask and
// shifted store data for word, store-left and store-right accesses.
module dmem_store_align
  import dmem_pkg::*;
(
  input  logic        write_l_i,
  input  logic        write_r_i,
  input  logic [1:0]  k_i,
  input  logic [31:0] data_i,
  output lane_mask_t  mask_o,
  output logic [31:0] data_o
);

  store_mode_t mode;
  logic [4:0]  sh_l;
  logic [4:0]  sh_r;

  always_comb begin
    mode = ST_WORD;
    if (write_l_i) begin
      mode = ST_LEFT;
    end else if (write_r_i) begin
      mode = ST_RIGHT;
    end
  end

  assign sh_l = {k_i, 3'b000};
  assign sh_r = {2'd3 - k_i, 3'b000};

  always_comb begin
    case (mode)
      ST_LEFT:  data_o = data_i >> sh_l;
      ST_RIGHT: data_o = data_i << sh_r;
      default:  data_o = data_i;
    endcase
  end

  assign mask_o = lane_mask(mode, k_i);

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory serving the MEM stage: registered reads, byte-lane
// merged stores, post-reset zero fill, test-image loader and sticky fault flag.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       MemAddr,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              WriteL,
  input  logic              WriteR,
  input  logic [31:0]       WriteData,
  output logic [31:0]       MemData,
  output logic              Ready,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [31:0]       LoadData,
  output logic              Fault,
  output logic [15:0]       FaultAddr
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_we;
  logic              ready_q;
  logic              fault_q;
  logic [15:0]       fault_addr_q;
  logic              rd_zero_q;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        k;
  logic              oor, bad, proc_req, rd_ok, rd_bad, wr_ok, fault_ev;

  lane_mask_t        align_mask;
  logic [31:0]       align_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  lane_mask_t        wr_mask;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;

  // FSM: state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (CLEAR_ON_RESET) begin
        state_q <= CLEAR;
      end else begin
        state_q <= READY;
      end
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) begin
        state_d = READY;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    clr_we = (state_q == CLEAR) && !Reset;
  end

  // Ready is registered so it reads 0 throughout reset even when the fill is skipped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_d == READY);
    end
  end

  assign word_idx = MemAddr[ADDR_W+1:2];
  assign k        = MemAddr[1:0];
  assign oor      = (MemAddr >> (ADDR_W + 2)) != 16'd0;

  assign bad = (MemRead && MemWrite)
            || (MemWrite && WriteL && WriteR)
            || (MemWrite && !WriteL && !WriteR && (k != 2'd0))
            || oor;

  // The loader owns the port for its cycle; a concurrent processor access is simply dropped.
  assign proc_req = ready_q && !LoadEn && (MemRead || MemWrite);
  assign fault_ev = proc_req && bad;
  assign rd_ok    = proc_req && MemRead && !bad;
  assign rd_bad   = proc_req && MemRead && bad;
  assign wr_ok    = proc_req && MemWrite && !bad;

  dmem_store_align u_align (
    .write_l_i (WriteL),
    .write_r_i (WriteR),
    .k_i       (k),
    .data_i    (WriteData),
    .mask_o    (align_mask),
    .data_o    (align_data)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = word_idx;
    wr_mask = align_mask;
    wr_data = align_data;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q;
      wr_mask = '1;
      wr_data = '0;
    end else if (ready_q && LoadEn) begin
      wr_en   = 1'b1;
      wr_addr = LoadAddr;
      wr_mask = '1;
      wr_data = LoadData;
    end else if (wr_ok) begin
      wr_en = 1'b1;
    end
  end

  // One byte-wide array per lane; the read returns pre-write contents.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [DEPTH];
    logic [BYTE_W-1:0] rd_lane_q;

    always_ff @(posedge Clock) begin
      if (wr_en && wr_mask[gi]) begin
        lane_mem[wr_addr] <= wr_data[gi*BYTE_W +: BYTE_W];
      end
      if (rd_ok) begin
        rd_lane_q <= lane_mem[word_idx];
      end
    end

    assign rd_word[gi*BYTE_W +: BYTE_W] = rd_lane_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_zero_q    <= 1'b1;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      if (rd_ok) begin
        rd_zero_q <= 1'b0;
      end else if (rd_bad) begin
        rd_zero_q <= 1'b1;
      end
      if (fault_ev && !fault_q) begin
        fault_q      <= 1'b1;
        fault_addr_q <= MemAddr;
      end
    end
  end

  assign MemData   = rd_zero_q ? '0 : rd_word;
  assign Ready     = ready_q;
  assign Fault     = fault_q;
  assign FaultAddr = fault_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (ADDR_W=4, zero fill enabled):
// expected read data is queued when a read is driven and compared a cycle later.
module tb_data_mem_responder;

  localparam int ADDR_W = 4;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [15:0]       MemAddr;
  logic              MemRead, MemWrite, WriteL, WriteR;
  logic [31:0]       WriteData;
  logic [31:0]       MemData;
  logic              Ready;
  logic              LoadEn;
  logic [ADDR_W-1:0] LoadAddr;
  logic [31:0]       LoadData;
  logic              Fault;
  logic [15:0]       FaultAddr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  data_mem_responder #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .MemAddr   (MemAddr),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .WriteL    (WriteL),
    .WriteR    (WriteR),
    .WriteData (WriteData),
    .MemData   (MemData),
    .Ready     (Ready),
    .LoadEn    (LoadEn),
    .LoadAddr  (LoadAddr),
    .LoadData  (LoadData),
    .Fault     (Fault),
    .FaultAddr (FaultAddr)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    WriteL   = 1'b0;
    WriteR   = 1'b0;
    LoadEn   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    MemAddr = a;
    MemRead = 1'b1;
    exp_q.push_back(exp);
    step();
    MemRead = 1'b0;
    check(tag, MemData, exp_q.pop_front());
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic l, input logic r);
    MemAddr   = a;
    WriteData = d;
    WriteL    = l;
    WriteR    = r;
    MemWrite  = 1'b1;
    step();
    idle();
  endtask

  task automatic ld(input logic [ADDR_W-1:0] w, input logic [31:0] d);
    LoadAddr = w;
    LoadData = d;
    LoadEn   = 1'b1;
    step();
    LoadEn = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!Ready && n < 200) begin
      step();
      n++;
    end
    check(tag, n, 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    Reset     = 1'b1;
    MemAddr   = '0;
    WriteData = '0;
    LoadAddr  = '0;
    LoadData  = '0;
    step();
    step();
    check("reset_ready", Ready, 32'd0);
    check("reset_fault", Fault, 32'd0);
    check("reset_faddr", FaultAddr, 32'd0);
    check("reset_memdata", MemData, 32'd0);

    Reset = 1'b0;
    wait_ready("clear_cycles");
    rd("read_cleared", 16'h0008, 32'h0000_0000);

    ld(4'd4, 32'h1122_3344);
    rd("load_read", 16'h0010, 32'h1122_3344);
    step();
    check("memdata_hold", MemData, 32'h1122_3344);

    wr(16'h0011, 32'hAABB_CCDD, 1'b1, 1'b0);
    rd("swl", 16'h0010, 32'h11AA_BBCC);

    ld(4'd4, 32'h1122_3344);
    wr(16'h0012, 32'hAABB_CCDD, 1'b0, 1'b1);
    rd("swr", 16'h0010, 32'hBBCC_DD44);

    wr(16'h0014, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rd("word_b2b", 16'h0014, 32'hDEAD_BEEF);
    check("no_fault_yet", Fault, 32'd0);

    wr(16'h0016, 32'h1234_5678, 1'b0, 1'b0);
    check("misalign_fault", Fault, 32'd1);
    check("misalign_faddr", FaultAddr, 32'h0000_0016);
    rd("misalign_unchanged", 16'h0014, 32'hDEAD_BEEF);
    rd("oor_read_zero", 16'h4000, 32'h0000_0000);
    check("oor_faddr_kept", FaultAddr, 32'h0000_0016);
    check("oor_fault_sticky", Fault, 32'd1);

    // Reset in clear cycle 7 restarts the full fill.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    repeat (7) step();
    Reset = 1'b1;
    step();
    check("midclear_ready", Ready, 32'd0);
    check("midclear_fault_clr", Fault, 32'd0);
    Reset = 1'b0;
    wait_ready("restart_cycles");
    rd("refilled_word4", 16'h0010, 32'h0000_0000);

    LoadAddr  = 4'd2;
    LoadData  = 32'h5566_7788;
    LoadEn    = 1'b1;
    MemAddr   = 16'h000C;
    WriteData = 32'h9999_9999;
    MemWrite  = 1'b1;
    step();
    idle();
    check("loader_no_fault", Fault, 32'd0);
    rd("loader_word", 16'h0008, 32'h5566_7788);
    rd("dropped_write", 16'h000C, 32'h0000_0000);

    MemAddr  = 16'h0008;
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    exp_q.push_back(32'h0000_0000);
    step();
    idle();
    check("rdwr_memdata", MemData, exp_q.pop_front());
    check("rdwr_faddr", FaultAddr, 32'h0000_0008);
    wr(16'h8000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("oor_write_faddr", FaultAddr, 32'h0000_0008);
    rd("after_faults", 16'h0008, 32'h5566_7788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
